mic1_microsequencer: RTL and testbench

- Microprogram sequencer for the 32-bit ALU/shifter datapath.
- Fetches 36-bit microinstructions from an external synchronous control store and drives the ALU opcode, shifter opcode, B-bus select and C-bus write enables.
- Latches the ALU N/Z flags and computes the next microaddress from the NEXT_ADDRESS and JAM fields.
- Sequences memory read/write/fetch through a req/ack handshake.

---
 rtl/mic1_microsequencer.sv | 151 +++++++++++++++
 tb/tb_mic1_microsequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic1_microsequencer.sv
// Mic-1 microprogram sequencer: LOAD/EXEC/MEM/HALT control around an external control store.
// Optional single-step gating of LOAD is enabled by defining MIC1_SINGLE_STEP_EN.
module mic1_microsequencer #(
  parameter int unsigned       ADDR_W     = 9,
  parameter int unsigned       CS_W       = 36,
  parameter logic [ADDR_W-1:0] START_ADDR = 9'h000,
  parameter logic [ADDR_W-1:0] HALT_ADDR  = 9'h1FF
) (
  input  logic              clk,
  input  logic              rst,
`ifdef MIC1_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic [ADDR_W-1:0] cs_addr,
  input  logic [CS_W-1:0]   cs_data,
  input  logic              n,
  input  logic              z,
  input  logic [7:0]        mbr,
  output logic [5:0]        alu_opcode,
  output logic [1:0]        shifter_opcode,
  output logic [3:0]        b_sel,
  output logic [8:0]        c_en,
  output logic              mem_req,
  output logic [2:0]        mem_op,
  input  logic              mem_ack,
  output logic              n_flag,
  output logic              z_flag,
  output logic [ADDR_W-1:0] mpc,
  output logic              halted
);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MEM  = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [5:0] ALU_IDLE = 6'b010000;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] mpc_q, mpc_d;
  logic [CS_W-1:0]   mir_q, mir_d;
  logic              n_flag_q, n_flag_d;
  logic              z_flag_q, z_flag_d;
  logic              load_go;

  logic [8:0] f_next;
  logic [2:0] f_jam;
  logic [2:0] f_mem;
  logic       halt_cond;

  // JAM = {JMPC, JAMN, JAMZ}; high bit ORs in N/Z, low byte ORs in MBR.
  function automatic logic [8:0] next_addr(input logic [8:0] na, input logic [2:0] jam,
                                           input logic nn, input logic zz,
                                           input logic [7:0] m);
    logic [8:0] r;
    r[8]   = na[8] | (jam[1] & nn) | (jam[0] & zz);
    r[7:0] = na[7:0] | (jam[2] ? m : 8'h00);
    return r;
  endfunction

`ifdef MIC1_SINGLE_STEP_EN
  assign load_go = step;
`else
  assign load_go = 1'b1;
`endif

  assign f_next    = mir_q[35:27];
  assign f_jam     = mir_q[26:24];
  assign f_mem     = mir_q[6:4];
  assign halt_cond = (f_next == HALT_ADDR) && (f_jam == 3'b000);

  assign cs_addr = mpc_q;
  assign mpc     = mpc_q;
  assign n_flag  = n_flag_q;
  assign z_flag  = z_flag_q;

  always_comb begin
    state_d        = state_q;
    mpc_d          = mpc_q;
    mir_d          = mir_q;
    n_flag_d       = n_flag_q;
    z_flag_d       = z_flag_q;
    alu_opcode     = ALU_IDLE;
    shifter_opcode = 2'b00;
    b_sel          = 4'h0;
    c_en           = 9'h000;
    mem_req        = 1'b0;
    mem_op         = 3'b000;
    halted         = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (load_go) begin
          mir_d   = cs_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_opcode     = mir_q[21:16];
        shifter_opcode = mir_q[23:22];
        b_sel          = mir_q[3:0];
        c_en           = mir_q[15:7];
        n_flag_d       = n;
        z_flag_d       = z;
        if (f_mem != 3'b000) begin
          mem_req = 1'b1;
          mem_op  = f_mem;
          // A same-cycle ack completes the access without visiting MEM.
          if (mem_ack) begin
            mpc_d   = ADDR_W'(next_addr(f_next, f_jam, n, z, mbr));
            state_d = halt_cond ? S_HALT : S_LOAD;
          end else begin
            state_d = S_MEM;
          end
        end else if (halt_cond) begin
          state_d = S_HALT;
        end else begin
          mpc_d   = ADDR_W'(next_addr(f_next, f_jam, n, z, mbr));
          state_d = S_LOAD;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_op  = f_mem;
        // Branch resolves against the flags captured during EXEC.
        if (mem_ack) begin
          mpc_d   = ADDR_W'(next_addr(f_next, f_jam, n_flag_q, z_flag_q, mbr));
          state_d = halt_cond ? S_HALT : S_LOAD;
        end
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_LOAD;
      mpc_q    <= START_ADDR;
      mir_q    <= '0;
      n_flag_q <= 1'b0;
      z_flag_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mpc_q    <= mpc_d;
      mir_q    <= mir_d;
      n_flag_q <= n_flag_d;
      z_flag_q <= z_flag_d;
    end
  end

endmodule

// File: tb/tb_mic1_microsequencer.sv
// Self-checking bench for mic1_microsequencer: directed steps plus randomized microinstructions
// checked against a per-microinstruction reference model. Handles MIC1_SINGLE_STEP_EN builds.
module tb_mic1_microsequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] cs_addr;
  logic [35:0] cs_data;
  logic       n, z;
  logic [7:0] mbr;
  logic [5:0] alu_opcode;
  logic [1:0] shifter_opcode;
  logic [3:0] b_sel;
  logic [8:0] c_en;
  logic       mem_req;
  logic [2:0] mem_op;
  logic       mem_ack;
  logic       n_flag, z_flag;
  logic [8:0] mpc;
  logic       halted;
`ifdef MIC1_SINGLE_STEP_EN
  logic       step;
  logic       step_hold;
`endif

  logic [35:0] cs_mem [512];
  logic [8:0]  exp_mpc;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          fail_cnt = 0;

  always #5 clk = ~clk;

  assign cs_data = cs_mem[cs_addr];

  mic1_microsequencer dut (
    .clk            (clk),
    .rst            (rst),
`ifdef MIC1_SINGLE_STEP_EN
    .step           (step),
`endif
    .cs_addr        (cs_addr),
    .cs_data        (cs_data),
    .n              (n),
    .z              (z),
    .mbr            (mbr),
    .alu_opcode     (alu_opcode),
    .shifter_opcode (shifter_opcode),
    .b_sel          (b_sel),
    .c_en           (c_en),
    .mem_req        (mem_req),
    .mem_op         (mem_op),
    .mem_ack        (mem_ack),
    .n_flag         (n_flag),
    .z_flag         (z_flag),
    .mpc            (mpc),
    .halted         (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] mk(input logic [8:0] na, input logic [2:0] jam,
                                     input logic [1:0] sh, input logic [5:0] alu,
                                     input logic [8:0] c, input logic [2:0] mem,
                                     input logic [3:0] b);
    return {na, jam, sh, alu, c, mem, b};
  endfunction

  // Reference next-address: plain integer OR-ing of the branch contributions.
  function automatic logic [8:0] model_next(input logic [35:0] w, input logic nv,
                                            input logic zv, input logic [7:0] m);
    int a;
    a = int'(w[35:27]);
    if (w[25] && nv) a = a | 256;
    if (w[24] && zv) a = a | 256;
    if (w[26]) a = a | int'(m);
    return 9'(a % 512);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one microinstruction starting in a LOAD cycle; dly = MEM cycles up to and including ack.
  task automatic run_uinstr(input logic [35:0] w, input logic nv, input logic zv,
                            input logic [7:0] mbrv, input int dly);
    logic [8:0] nxt;
    logic [2:0] memf;
    bit         halt_w;
    memf   = w[6:4];
    halt_w = (w[35:27] == 9'h1FF) && (w[26:24] == 3'b000);
    cs_mem[exp_mpc] = w;
    n = 1'($urandom); z = 1'($urandom); mbr = 8'($urandom); mem_ack = 1'($urandom);
`ifdef MIC1_SINGLE_STEP_EN
    step = 1'b1;
`endif
    chk("load_cs_addr", 32'(cs_addr), 32'(exp_mpc));
    chk("load_alu_idle", 32'(alu_opcode), 32'(6'b010000));
    chk("load_c_en", 32'(c_en), 32'(0));
    chk("load_mem_req", 32'(mem_req), 32'(0));
    tick();
`ifdef MIC1_SINGLE_STEP_EN
    step = step_hold;
`endif
    chk("exec_alu", 32'(alu_opcode), 32'(w[21:16]));
    chk("exec_shift", 32'(shifter_opcode), 32'(w[23:22]));
    chk("exec_b_sel", 32'(b_sel), 32'(w[3:0]));
    chk("exec_c_en", 32'(c_en), 32'(w[15:7]));
    chk("exec_mem_req", 32'(mem_req), 32'(memf != 3'b000));
    chk("exec_mem_op", 32'(mem_op), 32'(memf));
    chk("exec_mpc", 32'(mpc), 32'(exp_mpc));
    n = nv; z = zv; mbr = mbrv;
    if (memf != 3'b000) mem_ack = (dly == 0);
    else mem_ack = 1'($urandom);
    nxt = model_next(w, nv, zv, mbrv);
    tick();
    mem_ack = 1'b0;
    chk("n_flag", 32'(n_flag), 32'(nv));
    chk("z_flag", 32'(z_flag), 32'(zv));
    if (memf != 3'b000 && dly > 0) begin
      for (int k = 1; k <= dly; k++) begin
        chk("mem_req_hold", 32'(mem_req), 32'(1));
        chk("mem_op_hold", 32'(mem_op), 32'(memf));
        chk("mem_c_en", 32'(c_en), 32'(0));
        chk("mem_alu_idle", 32'(alu_opcode), 32'(6'b010000));
        chk("mem_mpc", 32'(mpc), 32'(exp_mpc));
        n = 1'($urandom); z = 1'($urandom);
        mbr = (k == dly) ? mbrv : 8'($urandom);
        mem_ack = (k == dly);
        tick();
        mem_ack = 1'b0;
      end
    end
    if (halt_w) begin
      if (memf != 3'b000) exp_mpc = nxt;
      chk("halted", 32'(halted), 32'(1));
      chk("halt_mpc", 32'(mpc), 32'(exp_mpc));
    end else begin
      exp_mpc = nxt;
      chk("next_mpc", 32'(mpc), 32'(exp_mpc));
      chk("not_halted", 32'(halted), 32'(0));
      chk("mem_req_drop", 32'(mem_req), 32'(0));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_mpc = 9'h000;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [35:0] w;
    logic [8:0]  na;
    logic [2:0]  jam, memf;
    for (int i = 0; i < 512; i++) cs_mem[i] = '0;
    n = 1'b0; z = 1'b0; mbr = 8'h00; mem_ack = 1'b0;
`ifdef MIC1_SINGLE_STEP_EN
    step = 1'b1; step_hold = 1'b1;
`endif
    exp_mpc = 9'h000;
    rst = 1'b1;
    #1;
    chk("rst_mpc", 32'(mpc), 32'(0));
    chk("rst_halted", 32'(halted), 32'(0));
    chk("rst_mem_req", 32'(mem_req), 32'(0));
    chk("rst_mem_op", 32'(mem_op), 32'(0));
    chk("rst_alu", 32'(alu_opcode), 32'(6'b010000));
    chk("rst_shift", 32'(shifter_opcode), 32'(0));
    chk("rst_b_sel", 32'(b_sel), 32'(0));
    chk("rst_c_en", 32'(c_en), 32'(0));
    chk("rst_n_flag", 32'(n_flag), 32'(0));
    chk("rst_z_flag", 32'(z_flag), 32'(0));
    do_reset();

    run_uinstr(mk(9'h005, 3'b000, 2'b00, 6'b111100, 9'h001, 3'b000, 4'h2), 1'b0, 1'b0, 8'h00, 0);
    chk("plain_to_5", 32'(mpc), 32'(9'h005));
    run_uinstr(mk(9'h010, 3'b010, 2'b01, 6'b001100, 9'h004, 3'b000, 4'h3), 1'b1, 1'b0, 8'h00, 0);
    chk("jamn_taken", 32'(mpc), 32'(9'h110));
    run_uinstr(mk(9'h010, 3'b010, 2'b10, 6'b011000, 9'h008, 3'b000, 4'h1), 1'b0, 1'b1, 8'h00, 0);
    chk("jamn_not_taken", 32'(mpc), 32'(9'h010));
    run_uinstr(mk(9'h100, 3'b100, 2'b00, 6'b110101, 9'h010, 3'b000, 4'h5), 1'b0, 1'b0, 8'h36, 0);
    chk("jmpc", 32'(mpc), 32'(9'h136));
    run_uinstr(mk(9'h020, 3'b001, 2'b00, 6'b111101, 9'h020, 3'b010, 4'h0), 1'b1, 1'b1, 8'h00, 3);
    chk("read_wait", 32'(mpc), 32'(9'h120));
    run_uinstr(mk(9'h030, 3'b000, 2'b11, 6'b000001, 9'h040, 3'b001, 4'h7), 1'b0, 1'b0, 8'h00, 0);
    chk("ack_in_exec", 32'(mpc), 32'(9'h030));

    // Asynchronous reset in the middle of a memory wait.
    cs_mem[exp_mpc] = mk(9'h044, 3'b000, 2'b00, 6'b111100, 9'h080, 3'b100, 4'h4);
    tick();
    tick();
    chk("wait_mem_req", 32'(mem_req), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'(0));
    chk("midrst_mpc", 32'(mpc), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    exp_mpc = 9'h000;

    run_uinstr(mk(9'h1FF, 3'b000, 2'b00, 6'b111100, 9'h1FF, 3'b000, 4'h9), 1'b0, 1'b0, 8'h00, 0);
    for (int i = 0; i < 20; i++) begin
      n = 1'($urandom); z = 1'($urandom); mem_ack = 1'($urandom); mbr = 8'($urandom);
      tick();
      chk("halt_stays", 32'(halted), 32'(1));
      chk("halt_mpc_frozen", 32'(mpc), 32'(0));
      chk("halt_c_en", 32'(c_en), 32'(0));
      chk("halt_mem_req", 32'(mem_req), 32'(0));
    end
    mem_ack = 1'b0;
    do_reset();
    run_uinstr(mk(9'h1FF, 3'b001, 2'b00, 6'b010100, 9'h002, 3'b000, 4'h6), 1'b0, 1'b1, 8'h00, 0);
    chk("jump_1ff_no_halt", 32'(mpc), 32'(9'h1FF));

    for (int i = 0; i < 150; i++) begin
      na   = 9'($urandom);
      jam  = 3'($urandom_range(0, 7));
      memf = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'b000;
      if (na == 9'h1FF && jam == 3'b000) jam = 3'b001;
      w = mk(na, jam, 2'($urandom), 6'($urandom), 9'($urandom), memf, 4'($urandom));
      run_uinstr(w, 1'($urandom), 1'($urandom), 8'($urandom), int'($urandom_range(0, 4)));
    end

`ifdef MIC1_SINGLE_STEP_EN
    step_hold = 1'b0;
    step = 1'b0;
    cs_mem[exp_mpc] = mk(9'h0AA, 3'b000, 2'b00, 6'b111100, 9'h1FF, 3'b000, 4'hF);
    for (int i = 0; i < 10; i++) begin
      chk("step_wait_c_en", 32'(c_en), 32'(0));
      chk("step_wait_alu", 32'(alu_opcode), 32'(6'b010000));
      chk("step_wait_mpc", 32'(mpc), 32'(exp_mpc));
      tick();
    end
    run_uinstr(mk(9'h0AA, 3'b000, 2'b00, 6'b111100, 9'h1FF, 3'b000, 4'hF), 1'b0, 1'b0, 8'h00, 0);
    cs_mem[exp_mpc] = mk(9'h055, 3'b000, 2'b00, 6'b111100, 9'h1FF, 3'b000, 4'hF);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("step_one_only_c_en", 32'(c_en), 32'(0));
      chk("step_one_only_mpc", 32'(mpc), 32'(9'h0AA));
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
